// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - byte-wide memory bus responder: RAM, UART TX FIFO, input port, cycle counter, halt
module mem_bus_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt,
    output logic        tx_overflow
);
    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]                ram [2**RAM_ADDR_WIDTH];
    logic [7:0]                ram_q;
    logic                      rd_ram_q;
    logic [7:0]                io_rd_q;
    logic [31:0]               cycle_cnt;
    logic [23:0]               snap;
    logic [7:0]                fifo_mem [TX_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          tx_count;

    logic                      io_sel;
    logic [2:0]                io_off;
    logic                      io_wr;
    logic                      io_rd;
    logic                      ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic [7:0]                io_rdata;
    logic                      push_req;
    logic [7:0]                push_data;
    logic                      halt_set;
    logic                      fifo_full;
    logic                      pop;
    logic                      push_ok;
    logic                      unused_addr;

    assign io_sel      = (mem_a[17:16] == 2'b11);
    assign io_off      = mem_a[2:0];
    assign io_wr       = io_sel && mem_wr && !halt;
    assign io_rd       = io_sel && !mem_wr;
    assign ram_we      = !io_sel && mem_wr;
    assign ram_idx     = mem_a[RAM_ADDR_WIDTH-1:0];
    assign unused_addr = ^mem_a[31:18];

    assign rx_ready = rst && io_rd && (io_off == 3'd0) && rx_valid;

    always_comb begin
        io_rdata = 8'h00;
        case (io_off)
            3'd0:    io_rdata = rx_valid ? rx_data : 8'h00;
            3'd4:    io_rdata = cycle_cnt[7:0];
            3'd5:    io_rdata = snap[7:0];
            3'd6:    io_rdata = snap[15:8];
            3'd7:    io_rdata = snap[23:16];
            default: io_rdata = 8'h00;
        endcase
    end

    // The halt write queues a 0x00 terminator even though data writes of 0x00 are dropped.
    assign halt_set  = io_wr && (io_off == 3'd4);
    assign push_req  = (io_wr && (io_off == 3'd0) && (mem_dout != 8'h00)) || halt_set;
    assign push_data = halt_set ? 8'h00 : mem_dout;

    assign tx_valid       = (tx_count != '0);
    assign fifo_full      = (tx_count == CNT_W'(TX_FIFO_DEPTH));
    assign pop            = tx_valid && tx_ready;
    assign push_ok        = push_req && (!fifo_full || pop);
    assign io_buffer_full = (tx_count >= CNT_W'(TX_FIFO_DEPTH - 1));
    assign tx_data        = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

    assign mem_din = rd_ram_q ? ram_q : io_rd_q;

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= mem_dout;
        ram_q <= ram[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ram_q    <= 1'b0;
            io_rd_q     <= 8'h00;
            cycle_cnt   <= 32'h0;
            snap        <= 24'h0;
            halt        <= 1'b0;
            tx_overflow <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tx_count    <= '0;
        end else begin
            rd_ram_q <= !io_sel && !mem_wr;
            io_rd_q  <= io_rd ? io_rdata : 8'h00;
            // Upper bytes are latched with byte 0 so a 4-byte read sequence is coherent.
            if (io_rd && (io_off == 3'd4)) snap <= cycle_cnt[31:8];
            if (!halt && !halt_set) cycle_cnt <= cycle_cnt + 32'd1;
            if (halt_set) halt <= 1'b1;
            if (push_req && fifo_full && !pop) tx_overflow <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   tx_count <= tx_count + CNT_W'(1);
                2'b01:   tx_count <= tx_count - CNT_W'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed self-checking bench for mem_bus_responder
module tb_mem_bus_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt;
    logic        tx_overflow;

    int checks = 0;
    int errors = 0;
    int tb_edges = 0;

    mem_bus_responder #(.RAM_ADDR_WIDTH(17), .TX_FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .halt(halt), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst) tb_edges <= tb_edges + 1;

    task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic wr);
        mem_a = a; mem_dout = d; mem_wr = wr;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus(32'h0000_0000, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        mem_a = 32'h0; mem_dout = 8'h00; mem_wr = 1'b0;
        #1;
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din: got %h expected 00", mem_din); end
        checks++; if ({io_buffer_full, tx_valid, rx_ready, halt, tx_overflow} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {io_buffer_full, tx_valid, rx_ready, halt, tx_overflow}); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_ram();
        bus(32'h0000_0123, 8'hA5, 1'b1);
        bus(32'h0000_0123, 8'h00, 1'b0);
        checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_rd_123: got %h expected a5", mem_din); end
        bus(32'h0001_FFFF, 8'h3C, 1'b1);
        bus(32'h0001_FFFF, 8'h00, 1'b0);
        checks++; if (mem_din !== 8'h3C) begin errors++; $display("FAIL ram_rd_1ffff: got %h expected 3c", mem_din); end
        bus(32'h0000_0123, 8'h00, 1'b0);
        checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_rd_123_again: got %h expected a5", mem_din); end
    endtask

    task automatic test_uart();
        tx_ready = 1'b0;
        bus(32'h0003_0000, 8'h41, 1'b1);
        bus(32'h0003_0000, 8'h00, 1'b1);
        bus(32'h0003_0000, 8'h42, 1'b1);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            errors++; $display("FAIL uart_head: got valid=%b data=%h expected valid=1 data=41", tx_valid, tx_data); end
        tx_ready = 1'b1;
        idle();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin
            errors++; $display("FAIL uart_second: got valid=%b data=%h expected valid=1 data=42", tx_valid, tx_data); end
        idle();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL uart_empty: got valid=%b expected 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_fifo_limits();
        logic [7:0] exp_seq [8];
        tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            bus(32'h0003_0000, 8'(i), 1'b1);
            if (i == 6) begin
                checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL full_after_6: got %b expected 0", io_buffer_full); end
            end
            if (i == 7) begin
                checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL full_after_7: got %b expected 1", io_buffer_full); end
            end
        end
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_after_8: got %b expected 0", tx_overflow); end
        tx_ready = 1'b1;
        bus(32'h0003_0000, 8'h99, 1'b1);
        checks++; if (io_buffer_full !== 1'b1 || tx_overflow !== 1'b0 || tx_data !== 8'h02) begin
            errors++; $display("FAIL push_pop_full: got full=%b ovf=%b head=%h expected full=1 ovf=0 head=02", io_buffer_full, tx_overflow, tx_data); end
        tx_ready = 1'b0;
        bus(32'h0003_0000, 8'h10, 1'b1);
        checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_on_9th: got %b expected 1", tx_overflow); end
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h99};
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp_seq[i]) begin
                errors++; $display("FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, exp_seq[i]); end
            idle();
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin
            errors++; $display("FAIL drained: got valid=%b full=%b expected 0 0", tx_valid, io_buffer_full); end
    endtask

    task automatic test_counter();
        int exp_cnt;
        logic [31:0] dw;
        repeat (300) idle();
        exp_cnt = tb_edges;
        bus(32'h0003_0004, 8'h00, 1'b0); dw[7:0]   = mem_din;
        bus(32'h0003_0005, 8'h00, 1'b0); dw[15:8]  = mem_din;
        bus(32'h0003_0006, 8'h00, 1'b0); dw[23:16] = mem_din;
        bus(32'h0003_0007, 8'h00, 1'b0); dw[31:24] = mem_din;
        checks++; if (dw !== 32'(exp_cnt)) begin errors++; $display("FAIL counter_dword: got %h expected %h", dw, 32'(exp_cnt)); end
    endtask

    task automatic test_input();
        rx_valid = 1'b1; rx_data = 8'h7E;
        mem_a = 32'h0003_0000; mem_dout = 8'h00; mem_wr = 1'b0;
        #1;
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_pulse: got %b expected 1", rx_ready); end
        @(posedge clk); #1;
        checks++; if (mem_din !== 8'h7E) begin errors++; $display("FAIL rx_data_read: got %h expected 7e", mem_din); end
        mem_a = 32'h0; #1;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_once: got %b expected 0", rx_ready); end
        rx_valid = 1'b0;
        mem_a = 32'h0003_0000; #1;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_novalid: got %b expected 0", rx_ready); end
        @(posedge clk); #1;
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_read_empty: got %h expected 00", mem_din); end
    endtask

    task automatic test_halt();
        int exp_cnt;
        logic [31:0] c1, c2;
        tx_ready = 1'b0;
        exp_cnt = tb_edges;
        bus(32'h0003_0004, 8'hFF, 1'b1);
        checks++; if (halt !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            errors++; $display("FAIL halt_write: got halt=%b valid=%b data=%h expected 1 1 00", halt, tx_valid, tx_data); end
        bus(32'h0003_0004, 8'h00, 1'b0); c1[7:0]   = mem_din;
        bus(32'h0003_0005, 8'h00, 1'b0); c1[15:8]  = mem_din;
        bus(32'h0003_0006, 8'h00, 1'b0); c1[23:16] = mem_din;
        bus(32'h0003_0007, 8'h00, 1'b0); c1[31:24] = mem_din;
        checks++; if (c1 !== 32'(exp_cnt)) begin errors++; $display("FAIL halt_cnt_first: got %h expected %h", c1, 32'(exp_cnt)); end
        repeat (50) idle();
        bus(32'h0003_0004, 8'h00, 1'b0); c2[7:0]   = mem_din;
        bus(32'h0003_0005, 8'h00, 1'b0); c2[15:8]  = mem_din;
        bus(32'h0003_0006, 8'h00, 1'b0); c2[23:16] = mem_din;
        bus(32'h0003_0007, 8'h00, 1'b0); c2[31:24] = mem_din;
        checks++; if (c2 !== 32'(exp_cnt)) begin errors++; $display("FAIL halt_cnt_frozen: got %h expected %h", c2, 32'(exp_cnt)); end
        bus(32'h0003_0000, 8'h55, 1'b1);
        bus(32'h0000_0200, 8'h66, 1'b1);
        bus(32'h0000_0200, 8'h00, 1'b0);
        checks++; if (mem_din !== 8'h66) begin errors++; $display("FAIL ram_after_halt: got %h expected 66", mem_din); end
        tx_ready = 1'b1;
        idle();
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL halt_blocks_push: got valid=%b expected 0", tx_valid); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; #2; rst = 1'b1;
        @(negedge clk);
        bus(32'h0003_0000, 8'h11, 1'b1);
        bus(32'h0003_0000, 8'h22, 1'b1);
        bus(32'h0000_0123, 8'h00, 1'b0);
        checks++; if (mem_din !== 8'hA5 || tx_valid !== 1'b1 || halt !== 1'b0) begin
            errors++; $display("FAIL pre_reset_state: got din=%h valid=%b halt=%b expected a5 1 0", mem_din, tx_valid, halt); end
        #2; rst = 1'b0; #1;
        checks++; if ({mem_din, tx_data} !== 16'h0000 || {io_buffer_full, tx_valid, rx_ready, halt, tx_overflow} !== 5'b0) begin
            errors++; $display("FAIL mid_reset: got din=%h data=%h flags=%b expected 00 00 00000", mem_din, tx_data,
                                {io_buffer_full, tx_valid, rx_ready, halt, tx_overflow}); end
        @(negedge clk); rst = 1'b1;
        idle();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_discards: got valid=%b expected 0", tx_valid); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_uart();
        test_fifo_limits();
        test_counter();
        test_input();
        test_halt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Responder end of the CPU byte-wide memory bus (address, write data, read data, write strobe). It decodes each bus cycle into either a 128 KB byte RAM or the memory-mapped I/O window, and returns read data one cycle later. It owns the UART transmit FIFO that drives `io_buffer_full`, the input-byte port, the cycle counter readable at 0x30004, and the program-stop latch. It sits at the SoC level opposite the `cpu` top, replacing the ad-hoc RAM/HCI glue used in simulation.

## Interface
- `RAM_ADDR_WIDTH`, 17, RAM byte-address width; 2^17 bytes.
- `TX_FIFO_DEPTH`, 8, UART transmit FIFO entries; power of two, ≥4.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `mem_a`  input  32  bus address from CPU; only [17:0] are decoded.
- `mem_dout`  input  8  write data from CPU.
- `mem_wr`  input  1  1 = write cycle, 0 = read cycle.
- `mem_din`  output  8  read data to CPU, registered.
- `io_buffer_full`  output  1  TX FIFO almost-full, to CPU.
- `tx_data`  output  8  FIFO head byte.
- `tx_valid`  output  1  FIFO non-empty.
- `tx_ready`  input  1  UART accepts head byte this cycle.
- `rx_data`  input  8  input byte.
- `rx_valid`  input  1  `rx_data` holds an unread byte.
- `rx_ready`  output  1  one-cycle pulse: input byte consumed.
- `halt`  output  1  sticky, program-stop written.
- `tx_overflow`  output  1  sticky, push attempted while FIFO full.

## Operation
- Decode: `mem_a[17:16]==2'b11` selects I/O, otherwise RAM at `mem_a[16:0]`. I/O offsets use `mem_a[2:0]`. Unmapped I/O offsets read 0x00, and writes to them are ignored.
- Every cycle is a bus cycle. There is no idle encoding. The CPU must not park the address on 0x30000 with `mem_wr=0`.
- RAM write: byte stored at the rising edge. RAM read: `mem_din` holds the byte on the next cycle. A read after a write to the same address returns the new byte. RAM is not cleared by reset.
- 0x30000 read: `mem_din` ← `rx_valid ? rx_data : 0x00` next cycle. `rx_ready` pulses in the cycle the read is presented, and only if `rx_valid`=1.
- 0x30000 write: a nonzero byte is pushed to the TX FIFO. 0x00 is ignored.
- 0x30004 write: the byte 0x00 is pushed unconditionally, `halt` is set, and the cycle counter freezes.
- After `halt`, all I/O writes are ignored. RAM writes still complete.
- Cycle counter: 32-bit, starts at 0 at reset release, increments each cycle until `halt`, wraps 0xFFFFFFFF→0.
- 0x30004 read captures the counter into `snap` and returns byte 0 of the counter value. Reads at 0x30005/6/7 return `snap` bytes 1/2/3 and leave `snap` unchanged. This gives a coherent dword.
- TX FIFO:
  - Circular buffer with read/write pointers and a count in 0..DEPTH.
  - Pop occurs when `tx_valid && tx_ready`.
  - Push and pop in the same cycle leave the count unchanged. This is also legal when full: the pop frees the slot first.
  - A push when count==DEPTH with no pop is dropped and sets `tx_overflow`.
  - `io_buffer_full` = count ≥ DEPTH−1. The extra slot absorbs the one write already in flight from the CPU.

## Timing
- Reset (async assert): `mem_din`=0, `io_buffer_full`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=0, `halt`=0, `tx_overflow`=0. Counter, `snap`, pointers and count are cleared.
- Reset mid-FIFO-transfer discards all queued bytes.
- Read latency is exactly 1 cycle for both RAM and I/O. Write latency is 0: visible at the next edge.
- `io_buffer_full`, `tx_valid` and `tx_data` are registered-state derived and update the cycle after the push or pop.
- `rx_ready` is combinational from the current bus cycle and `rx_valid`.
- The counter value read at 0x30004 is the count of edges since reset release at the edge that captures the read.
- With DEPTH=8, a CPU that writes back-to-back while `tx_ready`=0 sees `io_buffer_full` rise after the 7th push.

## Test plan
- RAM write then read: write 0xA5 to 0x00123 at cycle n, then read 0x00123 at cycle n+1 → `mem_din`=0xA5 at n+2. Read 0x1FFFF after writing 0x3C → 0x3C.
- UART path: with `tx_ready`=0, write 0x41, 0x00, 0x42 to 0x30000 → count 2, and the head byte is 0x41. Raise `tx_ready` → 0x41 then 0x42 are popped, then `tx_valid`=0.
- FIFO limits (DEPTH=8): 7 pushes → `io_buffer_full`=1. The 8th push is accepted. The 9th push is dropped and sets `tx_overflow`=1. Push and pop together while full → count stays 8 and no overflow.
- Counter coherence: run 300 cycles, then read 0x30004..0x30007 on consecutive cycles → the assembled dword equals the counter at the 0x30004 read, not at later cycles.
- Halt: write 0x30004 → 0x00 is queued, `halt`=1, and the counter is frozen across 50 cycles. A later write of 0x55 to 0x30000 is not queued.
- Input and reset: `rx_valid`=1 with `rx_data`=0x7E, read 0x30000 → `rx_ready` pulses once and `mem_din`=0x7E next cycle. Assert `rst` low mid-sequence → all outputs are 0 immediately.
